// File: rtl/spi_reg_ctrl.sv
// Command/register-access controller behind the SPI slave byte interface: one command byte
// per frame, then auto-incrementing register writes or prefetched reads with an ack timeout.
module spi_reg_ctrl #(
  parameter int          AW          = 7,
  parameter int          ACK_TIMEOUT = 64,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          ss_idle,
  input  logic [7:0]    recv_data,
  input  logic          recv_ready,
  input  logic          send_ready,
  output logic [7:0]    send_data,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_wr,
  output logic          reg_rd,
  input  logic [7:0]    reg_rdata,
  input  logic          reg_ack,
  output logic          busy,
  output logic          err_timeout
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_FETCH,
    RD_HOLD,
    WR_DATA,
    WR_ACK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    stage;
  logic          stage_vld;
  logic          strobe;
  logic          acked;
  logic          expired;
  logic          done;
  logic          entering;

  assign busy     = (state != IDLE);
  assign reg_rd   = (state == RD_FETCH);
  assign reg_wr   = (state == WR_ACK);
  assign strobe   = reg_rd | reg_wr;
  // An ack arriving on the expiry cycle still counts as a normal completion.
  assign acked    = strobe & reg_ack;
  assign expired  = strobe & ~reg_ack & (tmo_cnt == TW'(ACK_TIMEOUT - 1));
  assign done     = acked | expired;
  assign entering = (state_nxt != state) & ((state_nxt == RD_FETCH) | (state_nxt == WR_ACK));

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ss_idle) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = CMD;
        CMD:      if (recv_ready) state_nxt = recv_data[7] ? WR_DATA : RD_FETCH;
        RD_FETCH: if (done) state_nxt = RD_HOLD;
        RD_HOLD:  if (recv_ready) state_nxt = RD_FETCH;
        WR_DATA:  if (recv_ready) state_nxt = WR_ACK;
        WR_ACK:   if (done) state_nxt = WR_DATA;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      send_data   <= STATUS_BYTE;
      stage       <= '0;
      stage_vld   <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      if (entering) begin
        tmo_cnt <= '0;
      end else if (strobe) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (send_ready && stage_vld) begin
        send_data <= stage;
        stage_vld <= 1'b0;
      end

      // Staging loads below override the consume above in the same cycle.
      if (ss_idle || state == IDLE) begin
        stage     <= STATUS_BYTE;
        stage_vld <= 1'b1;
      end else begin
        case (state)
          CMD: begin
            if (recv_ready) begin
              reg_addr <= recv_data[AW-1:0];
              if (recv_data[7]) begin
                stage     <= 8'h00;
                stage_vld <= 1'b1;
              end
            end
          end
          RD_FETCH: begin
            if (done) begin
              stage       <= acked ? reg_rdata : 8'hFF;
              stage_vld   <= 1'b1;
              reg_addr    <= reg_addr + AW'(1);
              err_timeout <= err_timeout | expired;
            end
          end
          WR_DATA: begin
            if (recv_ready) begin
              reg_wdata <= recv_data;
              stage     <= 8'h00;
              stage_vld <= 1'b1;
            end
          end
          WR_ACK: begin
            if (done) begin
              reg_addr    <= reg_addr + AW'(1);
              err_timeout <= err_timeout | expired;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: byte-level SPI slave model, register bus model, scoreboard queues.
module tb_spi_reg_ctrl;

  localparam int AW       = 7;
  localparam int TMO      = 64;
  localparam int ACK_DLY  = 2;
  localparam int BYTE_CYC = 8;

  logic          sclk = 1'b0;
  logic          rst = 1'b0;
  logic          ss_idle = 1'b1;
  logic [7:0]    recv_data = 8'h00;
  logic          recv_ready = 1'b0;
  logic          send_ready = 1'b1;
  logic [7:0]    send_data;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_wr;
  logic          reg_rd;
  logic [7:0]    reg_rdata = 8'h00;
  logic          reg_ack = 1'b0;
  logic          busy;
  logic          err_timeout;

  spi_reg_ctrl #(
    .AW          (AW),
    .ACK_TIMEOUT (TMO),
    .STATUS_BYTE (8'hA5)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .ss_idle     (ss_idle),
    .recv_data   (recv_data),
    .recv_ready  (recv_ready),
    .send_ready  (send_ready),
    .send_data   (send_data),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wr      (reg_wr),
    .reg_rd      (reg_rd),
    .reg_rdata   (reg_rdata),
    .reg_ack     (reg_ack),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial begin
    forever #5 sclk = ~sclk;
  end

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]    exp_resp[$];
  logic [AW-1:0] exp_rd[$];
  logic [14:0]   exp_wr[$];
  logic [7:0]    mem [0:127];
  logic          ack_en = 1'b1;
  int            excl_viol = 0;
  int            unexp_wr = 0;
  int            wr_pulses = 0;
  int            last_rd_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register bus: ack ACK_DLY cycles into a strobe when enabled.
  initial begin
    int            cnt;
    logic [AW-1:0] ea;
    logic [14:0]   w;
    cnt = 0;
    forever begin
      @(negedge sclk);
      reg_ack = 1'b0;
      if ((reg_wr || reg_rd) && ack_en) begin
        cnt++;
        if (cnt >= ACK_DLY) begin
          cnt = 0;
          reg_ack = 1'b1;
          if (reg_rd) begin
            reg_rdata = mem[reg_addr];
            if (exp_rd.size() > 0) begin
              ea = exp_rd.pop_front();
              check("rd_addr", reg_addr, ea);
            end
          end else if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            check("wr_addr", reg_addr, w[14:8]);
            check("wr_data", reg_wdata, w[7:0]);
            mem[reg_addr] = reg_wdata;
          end else begin
            unexp_wr++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    int   run;
    logic wr_prev;
    run = 0;
    wr_prev = 1'b0;
    forever begin
      @(negedge sclk);
      if (reg_rd && reg_wr) excl_viol++;
      if (reg_rd === 1'b1) begin
        run++;
      end else begin
        if (run != 0) last_rd_len = run;
        run = 0;
      end
      if (reg_wr === 1'b1 && !wr_prev) wr_pulses++;
      wr_prev = (reg_wr === 1'b1);
    end
  end

  task automatic xfer(input logic [7:0] mosi, input int gap);
    logic [7:0] e;
    @(negedge sclk);
    e = exp_resp.pop_front();
    check("miso", send_data, e);
    send_ready = 1'b0;
    repeat (BYTE_CYC) @(negedge sclk);
    check("miso_hold", send_data, e);
    recv_data  = mosi;
    recv_ready = 1'b1;
    send_ready = 1'b1;
    @(negedge sclk);
    recv_ready = 1'b0;
    repeat (gap) @(negedge sclk);
  endtask

  task automatic frame_start();
    @(negedge sclk);
    ss_idle = 1'b0;
    repeat (2) @(negedge sclk);
  endtask

  task automatic frame_end();
    @(negedge sclk);
    ss_idle = 1'b1;
    repeat (3) @(negedge sclk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[7'h7E] = 8'h3C; mem[7'h7F] = 8'h4D; mem[7'h00] = 8'h5E;
    mem[7'h11] = 8'h77; mem[7'h20] = 8'hC7; mem[7'h30] = 8'hE1;

    #2 rst = 1'b1;
    #2;
    check("rst_send_data", send_data, 8'hA5);
    check("rst_reg_addr", reg_addr, 7'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_reg_wr", reg_wr, 1'b0);
    check("rst_reg_rd", reg_rd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    repeat (3) @(negedge sclk);
    rst = 1'b0;
    repeat (2) @(negedge sclk);

    // write frame
    exp_resp.push_back(8'hA5); exp_resp.push_back(8'h00); exp_resp.push_back(8'h00);
    exp_wr.push_back({7'h05, 8'h11}); exp_wr.push_back({7'h06, 8'h22});
    frame_start();
    check("wr_busy", busy, 1'b1);
    xfer(8'h85, 6); xfer(8'h11, 6); xfer(8'h22, 6);
    frame_end();
    check("wr_pulses", wr_pulses, 2);
    check("wr_q_empty", exp_wr.size(), 0);

    // read frame with address wrap
    exp_resp.push_back(8'hA5); exp_resp.push_back(8'h3C);
    exp_resp.push_back(8'h4D); exp_resp.push_back(8'h5E);
    exp_rd.push_back(7'h7E); exp_rd.push_back(7'h7F);
    exp_rd.push_back(7'h00); exp_rd.push_back(7'h01);
    frame_start();
    xfer(8'h7E, 6); xfer(8'h00, 6); xfer(8'h00, 6); xfer(8'h00, 6);
    frame_end();
    check("rd_q_empty", exp_rd.size(), 0);

    // timeout on a read
    check("tmo_err_before", err_timeout, 1'b0);
    ack_en = 1'b0;
    exp_resp.push_back(8'hA5); exp_resp.push_back(8'hFF); exp_resp.push_back(8'h77);
    frame_start();
    xfer(8'h10, 80);
    check("tmo_len", last_rd_len, TMO);
    check("tmo_err", err_timeout, 1'b1);
    check("tmo_rd_low", reg_rd, 1'b0);
    ack_en = 1'b1;
    exp_rd.push_back(7'h11); exp_rd.push_back(7'h12);
    xfer(8'hFF, 6); xfer(8'hFF, 6);
    frame_end();
    check("tmo_next_q", exp_rd.size(), 0);

    // asynchronous reset mid-write
    ack_en = 1'b0;
    exp_resp.push_back(8'hA5); exp_resp.push_back(8'h00);
    frame_start();
    xfer(8'h83, 4); xfer(8'h44, 4);
    check("mid_reg_wr", reg_wr, 1'b1);
    check("mid_err_sticky", err_timeout, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("arst_reg_wr", reg_wr, 1'b0);
    check("arst_send_data", send_data, 8'hA5);
    check("arst_busy", busy, 1'b0);
    check("arst_err", err_timeout, 1'b0);
    check("arst_reg_addr", reg_addr, 7'h00);
    check("arst_reg_wdata", reg_wdata, 8'h00);
    @(negedge sclk);
    rst = 1'b0;
    ss_idle = 1'b1;
    repeat (3) @(negedge sclk);

    // send_ready held low while a fetch completes
    ack_en = 1'b1;
    exp_rd.push_back(7'h20);
    frame_start();
    check("stab_pre", send_data, 8'hA5);
    send_ready = 1'b0;
    repeat (BYTE_CYC) @(negedge sclk);
    recv_data = 8'h20;
    recv_ready = 1'b1;
    @(negedge sclk);
    recv_ready = 1'b0;
    repeat (10) @(negedge sclk);
    check("stab_hold", send_data, 8'hA5);
    send_ready = 1'b1;
    @(negedge sclk);
    check("stab_load", send_data, 8'hC7);
    frame_end();

    // frame abort during WR_ACK
    ack_en = 1'b0;
    exp_resp.push_back(8'hA5); exp_resp.push_back(8'h00);
    frame_start();
    xfer(8'h84, 4); xfer(8'h99, 4);
    check("abort_wr_before", reg_wr, 1'b1);
    check("abort_busy_before", busy, 1'b1);
    ss_idle = 1'b1;
    @(negedge sclk);
    check("abort_wr_after", reg_wr, 1'b0);
    check("abort_busy_after", busy, 1'b0);
    repeat (3) @(negedge sclk);
    ack_en = 1'b1;
    exp_resp.push_back(8'hA5); exp_resp.push_back(8'hE1);
    exp_rd.push_back(7'h30); exp_rd.push_back(7'h31);
    frame_start();
    xfer(8'h30, 6); xfer(8'h00, 6);
    frame_end();

    check("resp_q_empty", exp_resp.size(), 0);
    check("wr_q_final", exp_wr.size(), 0);
    check("rd_q_final", exp_rd.size(), 0);
    check("strobe_excl", excl_viol, 0);
    check("unexp_wr", unexp_wr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
